icache_tag_ctrl: RTL

- Controller and arbiter for one single-port tag SCM bank of the L1.5 instruction cache.
- Shares the bank between two requesters: a lookup port for read hits and a refill port for tag writes.
- After reset, and on every flush request, sequences a full invalidate sweep that writes zero to every entry.
- Sits between the L1.5 cache controller and the tag RAM wrapper. Drives that wrapper's req/write/addr/wdata and consumes its rdata, which has 1-cycle read latency.

---
 rtl/icache_tag_ctrl_pkg.sv | 37 +++
 rtl/icache_tag_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/icache_tag_ctrl_pkg.sv
// ============================================================================
// Module : icache_tag_ctrl_pkg
// Brief  : Shared types, constants and helpers for the L1.5 I-cache tag
//          bank controller. ICACHE_TAG_PARITY_EN adds one even-parity bit
//          above the tag data in every RAM word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package icache_tag_ctrl_pkg;

  // Controller states: power-up sweep, normal arbitration, flush sweep
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_SERVE = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // All-zero tag marks an invalid entry (and carries valid even parity)
  localparam logic [63:0] TAG_INVALID = '0;

  // Extra RAM bits carried next to each tag
`ifdef ICACHE_TAG_PARITY_EN
  localparam int PARITY_W = 1;
`else
  localparam int PARITY_W = 0;
`endif

  // Even parity bit: makes the total number of ones in {parity, data} even.
  // Callers zero-extend their tag into the 64-bit argument.
  function automatic logic tag_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_tag_ctrl.sv
// ============================================================================
// Module : icache_tag_ctrl
// Brief  : Arbiter and invalidate sequencer for one single-port tag SCM bank.
//          Refill writes win over lookup reads; a pending flush wins over
//          both. After reset and after each flush request the whole bank is
//          swept to zero, one entry per cycle.
//          Optional: ICACHE_TAG_PARITY_EN stores even parity in the RAM MSB
//          and reports corrupted lookups on lk_perr_o as a miss.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_tag_ctrl
  import icache_tag_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 7
) (
  input  logic                             clk,
  input  logic                             rst_n,
  // flush control
  input  logic                             flush_req_i,
  output logic                             flush_ack_o,
  output logic                             busy_o,
  // lookup port
  input  logic                             lk_req_i,
  input  logic [ADDR_WIDTH-1:0]            lk_addr_i,
  output logic                             lk_gnt_o,
  output logic                             lk_rvalid_o,
  output logic [DATA_WIDTH-1:0]            lk_rdata_o,
`ifdef ICACHE_TAG_PARITY_EN
  output logic                             lk_perr_o,
`endif
  // refill port
  input  logic                             rf_req_i,
  input  logic [ADDR_WIDTH-1:0]            rf_addr_i,
  input  logic [DATA_WIDTH-1:0]            rf_wdata_i,
  output logic                             rf_gnt_o,
  // tag RAM wrapper
  output logic                             ram_req_o,
  output logic                             ram_write_o,
  output logic [ADDR_WIDTH-1:0]            ram_addr_o,
  output logic [DATA_WIDTH+PARITY_W-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH+PARITY_W-1:0]   ram_rdata_i
);

  localparam int                    RAM_W   = DATA_WIDTH + PARITY_W;
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_flush_pend;
  logic                    r_flush_ack;
  logic                    r_lk_rvalid;

  logic                    w_serve;
  logic                    w_rf_gnt;
  logic                    w_lk_gnt;
  logic                    w_ram_req;
  logic                    w_ram_write;
  logic [ADDR_WIDTH-1:0]   w_ram_addr;
  logic [RAM_W-1:0]        w_ram_wdata;
  logic [RAM_W-1:0]        w_rf_word;
  logic [DATA_WIDTH-1:0]   w_rd_tag;
  logic                    w_perr;

  // Grants only exist in SERVE with no flush waiting; refill beats lookup
  assign w_serve  = (r_state == ST_SERVE);
  assign w_rf_gnt = w_serve && !r_flush_pend && rf_req_i;
  assign w_lk_gnt = w_serve && !r_flush_pend && !rf_req_i && lk_req_i;

  assign w_rd_tag = ram_rdata_i[DATA_WIDTH-1:0];

`ifdef ICACHE_TAG_PARITY_EN
  assign w_rf_word = {tag_parity(64'(rf_wdata_i)), rf_wdata_i};
  assign w_perr    = r_lk_rvalid &&
                     (tag_parity(64'(w_rd_tag)) != ram_rdata_i[DATA_WIDTH]);
  assign lk_perr_o = w_perr;
`else
  assign w_rf_word = rf_wdata_i;
  assign w_perr    = 1'b0;
`endif

  // RAM command mux: sweep, then refill write, then lookup read, else idle
  always_comb begin
    w_ram_req   = 1'b0;
    w_ram_write = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = RAM_W'(TAG_INVALID);
    if (!w_serve) begin
      w_ram_req   = 1'b1;
      w_ram_write = 1'b1;
      w_ram_addr  = r_cnt;
    end else if (w_rf_gnt) begin
      w_ram_req   = 1'b1;
      w_ram_write = 1'b1;
      w_ram_addr  = rf_addr_i;
      w_ram_wdata = w_rf_word;
    end else if (w_lk_gnt) begin
      w_ram_req   = 1'b1;
      w_ram_addr  = lk_addr_i;
    end
  end

  // The sweep state is already INIT while rst_n is low; gating the strobes
  // keeps the RAM quiet until reset is released.
  assign ram_req_o   = w_ram_req && rst_n;
  assign ram_write_o = w_ram_write && rst_n;
  assign ram_addr_o  = w_ram_addr;
  assign ram_wdata_o = w_ram_wdata;

  assign rf_gnt_o    = w_rf_gnt;
  assign lk_gnt_o    = w_lk_gnt;
  assign busy_o      = !w_serve;
  assign flush_ack_o = r_flush_ack;
  assign lk_rvalid_o = r_lk_rvalid;
  // A corrupted entry reads back as invalid so the lookup simply misses
  assign lk_rdata_o  = (r_lk_rvalid && !w_perr) ? w_rd_tag
                                                : DATA_WIDTH'(TAG_INVALID);

  // Sequencer: sweep counter, flush bookkeeping and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_flush_ack  <= 1'b0;
      r_lk_rvalid  <= 1'b0;
    end else begin
      r_flush_ack  <= 1'b0;
      r_lk_rvalid  <= w_lk_gnt;
      // New requests always latch; a waiting one is consumed on FLUSH entry
      r_flush_pend <= flush_req_i || (r_flush_pend && !w_serve);
      case (r_state)
        ST_INIT, ST_FLUSH: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_MAX) begin
            r_state     <= ST_SERVE;
            r_cnt       <= '0;
            r_flush_ack <= (r_state == ST_FLUSH);
          end
        end
        ST_SERVE: begin
          r_cnt <= '0;
          if (r_flush_pend) begin
            r_state <= ST_FLUSH;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
